// File: rtl/uart_loader.sv
// UART boot loader: frames bytes from buart into 16-bit words, writes RAM port A, holds j1 in reset while loading.
// Latency: a byte is consumed and processed in the rx_rd cycle; RAM write and reply strobes are registered (next cycle).
// Backpressure: rx_rd only while not replying; the reply waits for ~tx_busy; bytes stay in buart until accepted.
module uart_loader #(
  parameter int         ADDR_W  = 9,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 200000,
  parameter logic [7:0] ACK     = 8'h06,
  parameter logic [7:0] NAK     = 8'h15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              tx_busy,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_d,
  output logic              mem_wr,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, D_LO, D_HI, CSUM, REPLY} state_t;

  state_t            state;
  logic              gap;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        sum;
  logic [7:0]        lo;
  logic [15:0]       count;
  logic [TW-1:0]     timer;
  logic              reply_ack;
  logic [15:0]       len;

  // Length as it will be once the LEN_HI byte lands.
  assign len = {rx_data, count[7:0]};

  // Take a byte when buart has one, except straight after a read and while a reply is pending.
  assign rx_rd = rx_valid & ~gap & (state != REPLY);

  // gap blocks a second read of the same byte until buart drops rx_valid.
  always_ff @(posedge clk) begin
    if (reset)          gap <= 1'b0;
    else if (rx_rd)     gap <= 1'b1;
    else if (!rx_valid) gap <= 1'b0;
  end

  // Frame parser, RAM writer, inter-byte timeout and reply generator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      sum       <= '0;
      lo        <= '0;
      count     <= '0;
      timer     <= '0;
      reply_ack <= 1'b0;
      tx_wr     <= 1'b0;
      tx_data   <= '0;
      mem_addr  <= '0;
      mem_d     <= '0;
      mem_wr    <= 1'b0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      tx_wr  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_rd && rx_data == SYNC) begin
            state    <= LEN_LO;
            cpu_hold <= 1'b1;
            addr     <= '0;
            sum      <= '0;
            timer    <= '0;
          end
        end
        REPLY: begin
          if (!tx_busy) begin
            tx_wr   <= 1'b1;
            tx_data <= reply_ack ? ACK : NAK;
            done    <= reply_ack;
            err     <= ~reply_ack;
            if (reply_ack) cpu_hold <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          if (rx_rd) begin
            timer <= '0;
            case (state)
              LEN_LO: begin
                count[7:0] <= rx_data;
                state      <= LEN_HI;
              end
              LEN_HI: begin
                count[15:8] <= rx_data;
                if ({1'b0, len} > 17'(DEPTH)) begin
                  reply_ack <= 1'b0;
                  state     <= REPLY;
                end else if (len == 16'd0) begin
                  state <= CSUM;
                end else begin
                  state <= D_LO;
                end
              end
              D_LO: begin
                lo    <= rx_data;
                sum   <= sum + rx_data;
                state <= D_HI;
              end
              D_HI: begin
                mem_d    <= {rx_data, lo};
                mem_addr <= addr;
                mem_wr   <= 1'b1;
                sum      <= sum + rx_data;
                addr     <= addr + 1'b1;
                count    <= count - 16'd1;
                state    <= (count == 16'd1) ? CSUM : D_LO;
              end
              CSUM: begin
                reply_ack <= (rx_data == sum);
                state     <= REPLY;
              end
              default: state <= IDLE;
            endcase
          end else if (timer == TLAST) begin
            // Sender went quiet mid-frame: reject; words already written stay in RAM.
            reply_ack <= 1'b0;
            state     <= REPLY;
          end else begin
            timer <= timer + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed frames plus randomized frames against a frame-level model.
// The model turns a whole frame into expected RAM writes and a reply byte; one compare process
// checks every mem_wr / tx_wr / done / err against those queues on each falling edge.
module tb_uart_loader;
  localparam int         ADDR_W  = 9;
  localparam int         DEPTH   = 512;
  localparam int         TIMEOUT = 300;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;

  typedef logic [7:0] b8_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_rd;
  logic              tx_busy = 1'b0;
  logic              tx_wr;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_d;
  logic              mem_wr;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tx_cyc = 0;
  int rd_cyc = 0;
  logic [24:0] exp_wr[$];
  b8_t         exp_tx[$];
  logic [24:0] ew;
  b8_t         et;

  uart_loader #(.ADDR_W(ADDR_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT), .ACK(ACK), .NAK(NAK)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data), .mem_addr(mem_addr), .mem_d(mem_d),
    .mem_wr(mem_wr), .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: what a whole byte sequence (starting with SYNC) must produce.
  // Too few bytes means the sender went silent, which ends in a NAK.
  task automatic model_frame(input b8_t fb[$]);
    int len;
    logic [7:0] s;
    logic [ADDR_W-1:0] a;
    if (fb.size() < 3) begin exp_tx.push_back(NAK); return; end
    len = int'({fb[2], fb[1]});
    if (len > DEPTH) begin exp_tx.push_back(NAK); return; end
    s = 8'h00;
    a = '0;
    for (int w = 0; w < len; w++) begin
      if (fb.size() < 5 + 2 * w) begin exp_tx.push_back(NAK); return; end
      s = s + fb[3 + 2 * w] + fb[4 + 2 * w];
      exp_wr.push_back({a, fb[4 + 2 * w], fb[3 + 2 * w]});
      a = a + 1'b1;
    end
    if (fb.size() < 4 + 2 * len) exp_tx.push_back(NAK);
    else exp_tx.push_back((fb[3 + 2 * len] == s) ? ACK : NAK);
  endtask

  // Compare process: every write, reply and pulse is matched against the model queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr) begin
        if (exp_wr.size() == 0) check_eq("mem_wr_unexpected", 32'(mem_wr), 32'd0);
        else begin
          ew = exp_wr.pop_front();
          check_eq("mem_write_addr_data", 32'({mem_addr, mem_d}), 32'(ew));
        end
      end
      if (tx_wr) begin
        tx_cyc = cyc;
        if (exp_tx.size() == 0) check_eq("tx_wr_unexpected", 32'(tx_wr), 32'd0);
        else begin
          et = exp_tx.pop_front();
          check_eq("tx_data", 32'(tx_data), 32'(et));
          check_eq("done_pulse", 32'(done), 32'(et == ACK));
          check_eq("err_pulse", 32'(err), 32'(et == NAK));
          check_eq("cpu_hold_at_reply", 32'(cpu_hold), 32'(et == NAK));
        end
      end else begin
        check_eq("pulse_without_tx", 32'({done, err}), 32'd0);
      end
    end
  end

  // Present one byte; hold it for 'hold' cycles after the first read, then drop rx_valid.
  task automatic send_byte(input b8_t b, input int hold);
    int rds;
    int waited;
    rds = 0;
    waited = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (rds == 0 && waited < 2000) begin
      @(negedge clk);
      if (rx_rd) begin rds++; rd_cyc = cyc; end
      @(posedge clk); #1;
      waited++;
    end
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      if (rx_rd) rds++;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rx_rd_per_byte", 32'(rds), 32'd1);
  endtask

  task automatic send_frame(input b8_t fb[$], input int hold, input int gapmax);
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], hold);
      if (i == 0 && fb[0] == SYNC) check_eq("cpu_hold_in_frame", 32'(cpu_hold), 32'd1);
      repeat ($urandom_range(0, gapmax)) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_reply();
    int n;
    n = 0;
    while (exp_tx.size() != 0 && n < TIMEOUT + 3000) begin
      @(posedge clk);
      n++;
    end
    check_eq("reply_seen", 32'(exp_tx.size()), 32'd0);
    check_eq("writes_drained", 32'(exp_wr.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    b8_t fb[$];
    b8_t f1[$];
    b8_t b;
    b8_t s;
    int len;
    int drop_cyc;

    f1 = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("reset_ctrl", 32'({rx_rd, tx_wr, mem_wr, cpu_hold, done, err}), 32'd0);
    check_eq("reset_data", 32'({tx_data, mem_addr, mem_d}), 32'd0);

    // 1: good two-word frame; model pinned to hand-computed words and ACK.
    model_frame(f1);
    check_eq("model_w0", 32'(exp_wr[0]), 32'({9'd0, 16'h1234}));
    check_eq("model_w1", 32'(exp_wr[1]), 32'({9'd1, 16'h5678}));
    check_eq("model_reply_ack", 32'(exp_tx[0]), 32'h06);
    send_frame(f1, 1, 3);
    wait_reply();
    check_eq("cpu_hold_after_ack", 32'(cpu_hold), 32'd0);

    // 2: same frame with a bad checksum -> words written, NAK, hold stays on.
    fb = f1;
    fb[7] = 8'h15;
    model_frame(fb);
    check_eq("model_reply_nak", 32'(exp_tx[0]), 32'h15);
    send_frame(fb, 1, 3);
    wait_reply();
    repeat (5) @(posedge clk);
    #1 check_eq("cpu_hold_after_nak", 32'(cpu_hold), 32'd1);

    // 3: empty frame ACKs; LEN=513 NAKs straight after LEN_HI.
    fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
    model_frame(fb);
    send_frame(fb, 1, 0);
    wait_reply();
    check_eq("cpu_hold_after_empty_ack", 32'(cpu_hold), 32'd0);
    fb = '{8'hA5, 8'h01, 8'h02};
    model_frame(fb);
    send_frame(fb, 1, 0);
    wait_reply();
    check_eq("len_too_big_reply_delay", 32'(tx_cyc - rd_cyc), 32'd2);

    // 4: truncated frame -> NAK exactly TIMEOUT cycles of silence after the last byte.
    fb = '{8'hA5, 8'h01, 8'h00, 8'h34};
    model_frame(fb);
    send_frame(fb, 1, 0);
    wait_reply();
    check_eq("timeout_reply_delay", 32'(tx_cyc - rd_cyc), 32'(TIMEOUT + 2));

    // 5: slow-dropping rx_valid, and the reply held off by tx_busy.
    model_frame(f1);
    for (int i = 0; i < 7; i++) send_byte(f1[i], 3);
    tx_busy = 1'b1;
    send_byte(f1[7], 3);
    repeat (50) @(posedge clk);
    #1 tx_busy = 1'b0;
    drop_cyc = cyc;
    wait_reply();
    check_eq("tx_after_busy_drop", 32'(tx_cyc - drop_cyc), 32'd1);

    // 6: reset mid-frame after the D_LO byte, then a normal load.
    fb = '{8'hA5, 8'h01, 8'h00, 8'h34};
    send_frame(fb, 1, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("cpu_hold_after_reset", 32'(cpu_hold), 32'd0);
    repeat (TIMEOUT + 20) @(posedge clk);
    #1;
    model_frame(f1);
    send_frame(f1, 1, 2);
    wait_reply();

    // Randomized frames with leading junk, random holds, gaps and checksums.
    for (int f = 0; f < 14; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        send_byte(b, 1);
      end
      len = $urandom_range(0, 6);
      s = 8'h00;
      fb = {};
      fb.push_back(SYNC);
      fb.push_back(8'(len));
      fb.push_back(8'h00);
      for (int j = 0; j < 2 * len; j++) begin
        b = 8'($urandom);
        fb.push_back(b);
        s = s + b;
      end
      if ($urandom_range(0, 2) == 0) s = s ^ 8'($urandom_range(1, 255));
      fb.push_back(s);
      model_frame(fb);
      send_frame(fb, $urandom_range(1, 3), 5);
      wait_reply();
    end

    // Largest legal frame: 512 words filling every address.
    s = 8'h00;
    fb = {};
    fb.push_back(SYNC);
    fb.push_back(8'h00);
    fb.push_back(8'h02);
    for (int j = 0; j < 2 * DEPTH; j++) begin
      b = 8'($urandom);
      fb.push_back(b);
      s = s + b;
    end
    fb.push_back(s);
    model_frame(fb);
    send_frame(fb, 1, 0);
    wait_reply();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
